// File: rtl/cache_lru_tagsim.sv
// Set-associative cache tag/replacement model: true-LRU ages, valid/ready requests,
// saturating statistics and a set-walking flush. Optional dirty tracking: CACHE_WRITEBACK_EN.
module cache_lru_tagsim #(
  parameter int ADDR_W      = 31,
  parameter int CACHE_BYTES = 8192,
  parameter int LINE_BYTES  = 32,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 31,
  localparam int SETS  = CACHE_BYTES / (LINE_BYTES * WAYS),
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 0,
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W,
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk_41,
  input  logic              rst_n_41,
  input  logic              req_valid_41,
  output logic              req_ready_41,
  input  logic [ADDR_W-1:0] req_addr_41,
  input  logic              req_wr_41,
  input  logic              flush_41,
  output logic              resp_valid_41,
  output logic              resp_hit_41,
  output logic [AGE_W-1:0]  resp_way_41,
  output logic              resp_evict_41,
  output logic              resp_wb_41,
  output logic              flush_done_41,
  output logic [CNT_W-1:0]  hits_41,
  output logic [CNT_W-1:0]  misses_41,
  output logic [CNT_W-1:0]  evictions_41,
  output logic [CNT_W-1:0]  writebacks_41
);

  // Handshake: a request or flush is taken on a rising edge where req_ready_41 is high
  // (IDLE); req_ready_41 drops for the lookup cycle and for the whole flush walk.
  localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [SET_W-1:0]  flush_idx_q, flush_idx_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic              dirty_d [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [AGE_W-1:0]  age_d   [SETS][WAYS];

  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [AGE_W-1:0]  resp_way_q, resp_way_d;
  logic              resp_evict_q, resp_evict_d;
  logic              resp_wb_q, resp_wb_d;
  logic              flush_done_q, flush_done_d;
  logic [CNT_W-1:0]  hits_q, hits_d, misses_q, misses_d;
  logic [CNT_W-1:0]  evicts_q, evicts_d, wbs_q, wbs_d;

  logic [SET_W-1:0]  lk_set;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit, inv_found, lk_evict, lk_wb;
  logic [AGE_W-1:0]  hit_way, inv_way, lru_way, tgt_way, tgt_age;
  logic [AGE_W:0]    fl_dirty;
  logic              unused_off;

  assign unused_off = ^(addr_q & ADDR_W'(LINE_BYTES - 1));

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    lk_set    = (SETS == 1) ? '0 : SET_W'(addr_q >> OFF_W);
    lk_tag    = TAG_W'(addr_q >> (OFF_W + IDX_W));
    lk_hit    = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    fl_dirty  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        lk_hit  = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!inv_found && !valid_q[lk_set][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[lk_set][w] == '0) lru_way = AGE_W'(w);
      fl_dirty = fl_dirty + {{AGE_W{1'b0}}, valid_q[flush_idx_q][w] & dirty_q[flush_idx_q][w]};
    end
    // Invalid ways are always filled before anything valid is displaced.
    tgt_way  = lk_hit ? hit_way : (inv_found ? inv_way : lru_way);
    lk_evict = !lk_hit && !inv_found;
    lk_wb    = lk_evict && dirty_q[lk_set][tgt_way];
    tgt_age  = age_q[lk_set][tgt_way];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    flush_idx_d  = flush_idx_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_evict_d = resp_evict_q;
    resp_wb_d    = resp_wb_q;
    flush_done_d = 1'b0;
    hits_d       = hits_q;
    misses_d     = misses_q;
    evicts_d     = evicts_q;
    wbs_d        = wbs_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_41) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end else if (req_valid_41) begin
          state_d = ST_LOOKUP;
          addr_d  = req_addr_41;
          wr_d    = req_wr_41;
        end
      end
      ST_LOOKUP: begin
        state_d                 = ST_IDLE;
        tag_d[lk_set][tgt_way]   = lk_tag;
        valid_d[lk_set][tgt_way] = 1'b1;
        if (WB_EN) dirty_d[lk_set][tgt_way] = lk_hit ? (dirty_q[lk_set][tgt_way] | wr_q) : wr_q;
        // Ages stay a permutation of 0..WAYS-1: older-than-accessed ways shift down.
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[lk_set][w] > tgt_age) age_d[lk_set][w] = age_q[lk_set][w] - 1'b1;
        end
        age_d[lk_set][tgt_way] = AGE_W'(WAYS - 1);
        resp_valid_d = 1'b1;
        resp_hit_d   = lk_hit;
        resp_way_d   = tgt_way;
        resp_evict_d = lk_evict;
        resp_wb_d    = WB_EN && lk_wb;
        if (lk_hit) hits_d = sat_add(hits_q, CNT_W'(1));
        else        misses_d = sat_add(misses_q, CNT_W'(1));
        if (lk_evict) evicts_d = sat_add(evicts_q, CNT_W'(1));
        if (WB_EN && lk_wb) wbs_d = sat_add(wbs_q, CNT_W'(1));
      end
      ST_FLUSH: begin
        for (int w = 0; w < WAYS; w++) begin
          valid_d[flush_idx_q][w] = 1'b0;
          dirty_d[flush_idx_q][w] = 1'b0;
          age_d[flush_idx_q][w]   = AGE_W'(w);
        end
        if (WB_EN) wbs_d = sat_add(wbs_q, CNT_W'(fl_dirty));
        if (flush_idx_q == SET_W'(SETS - 1)) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_41 or negedge rst_n_41) begin
    if (!rst_n_41) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      flush_idx_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_evict_q <= 1'b0;
      resp_wb_q    <= 1'b0;
      flush_done_q <= 1'b0;
      hits_q       <= '0;
      misses_q     <= '0;
      evicts_q     <= '0;
      wbs_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      flush_idx_q  <= flush_idx_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      age_q        <= age_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_evict_q <= resp_evict_d;
      resp_wb_q    <= resp_wb_d;
      flush_done_q <= flush_done_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      evicts_q     <= evicts_d;
      wbs_q        <= wbs_d;
    end
  end

  assign req_ready_41  = (state_q == ST_IDLE);
  assign resp_valid_41 = resp_valid_q;
  assign resp_hit_41   = resp_hit_q;
  assign resp_way_41   = resp_way_q;
  assign resp_evict_41 = resp_evict_q;
  assign resp_wb_41    = resp_wb_q;
  assign flush_done_41 = flush_done_q;
  assign hits_41       = hits_q;
  assign misses_41     = misses_q;
  assign evictions_41  = evicts_q;
  assign writebacks_41 = wbs_q;

endmodule

// File: tb/tb_cache_lru_tagsim.sv
// Scoreboard bench for cache_lru_tagsim at default geometry (64 sets, 4 ways, 32-byte lines).
module tb_cache_lru_tagsim;

  logic        clk_41 = 1'b0;
  logic        rst_n_41 = 1'b0;
  logic        req_valid_41 = 1'b0;
  logic        req_wr_41 = 1'b0;
  logic        flush_41 = 1'b0;
  logic [30:0] req_addr_41 = '0;
  logic        req_ready_41, resp_valid_41, resp_hit_41, resp_evict_41, resp_wb_41, flush_done_41;
  logic [1:0]  resp_way_41;
  logic [30:0] hits_41, misses_41, evictions_41, writebacks_41;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  resp_got;
  logic        resp_seen;
  int          resp_lat;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  cache_lru_tagsim dut (
    .clk_41(clk_41), .rst_n_41(rst_n_41),
    .req_valid_41(req_valid_41), .req_ready_41(req_ready_41),
    .req_addr_41(req_addr_41), .req_wr_41(req_wr_41), .flush_41(flush_41),
    .resp_valid_41(resp_valid_41), .resp_hit_41(resp_hit_41), .resp_way_41(resp_way_41),
    .resp_evict_41(resp_evict_41), .resp_wb_41(resp_wb_41), .flush_done_41(flush_done_41),
    .hits_41(hits_41), .misses_41(misses_41), .evictions_41(evictions_41),
    .writebacks_41(writebacks_41)
  );

  always #5 clk_41 = ~clk_41;

  // Response encoding: {hit, way[1:0], evict, wb}
  function automatic logic [4:0] mk(input bit hit, input int way, input bit ev, input bit wb);
    return {hit, 2'(way), ev, wb};
  endfunction

  task automatic apply_reset();
    rst_n_41 = 1'b0;
    req_valid_41 = 1'b0;
    flush_41 = 1'b0;
    req_wr_41 = 1'b0;
    req_addr_41 = '0;
    repeat (2) @(negedge clk_41);
    rst_n_41 = 1'b1;
    @(negedge clk_41);
  endtask

  task automatic issue(input logic [30:0] a, input logic w);
    int n;
    @(negedge clk_41);
    req_valid_41 = 1'b1;
    req_addr_41 = a;
    req_wr_41 = w;
    n = 0;
    while (!req_ready_41 && n < 200) begin
      @(negedge clk_41);
      n++;
    end
    @(posedge clk_41);
    #1 req_valid_41 = 1'b0;
    resp_seen = 1'b0;
    resp_got = '0;
    resp_lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_41);
      if (resp_valid_41) begin
        resp_seen = 1'b1;
        resp_got = {resp_hit_41, resp_way_41, resp_evict_41, resp_wb_41};
        resp_lat = i;
        break;
      end
    end
  endtask

  task automatic do_flush(input bit with_req, output int ready_low, output int done_cnt,
                          output bit saw_resp);
    @(negedge clk_41);
    flush_41 = 1'b1;
    req_valid_41 = with_req;
    req_addr_41 = 31'h2000;
    @(posedge clk_41);
    #1 flush_41 = 1'b0;
    req_valid_41 = 1'b0;
    ready_low = 0;
    done_cnt = 0;
    saw_resp = 1'b0;
    while (ready_low < 300) begin
      @(negedge clk_41);
      if (flush_done_41) done_cnt++;
      if (resp_valid_41) saw_resp = 1'b1;
      if (req_ready_41) break;
      ready_low++;
    end
    repeat (3) begin
      @(negedge clk_41);
      if (flush_done_41) done_cnt++;
      if (resp_valid_41) saw_resp = 1'b1;
    end
  endtask

  task automatic test_reset_hit();
    logic [4:0] e;
    apply_reset();
    n_checks++; if (req_ready_41 !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", req_ready_41); end
    n_checks++; if (resp_valid_41 !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid_41); end
    n_checks++; if (flush_done_41 !== 1'b0) begin n_fail++; $display("FAIL rst_flush_done: got %b exp 0", flush_done_41); end
    n_checks++; if ({resp_hit_41, resp_way_41, resp_evict_41, resp_wb_41} !== 5'b0) begin n_fail++; $display("FAIL rst_resp_fields: got %b exp 0", {resp_hit_41, resp_way_41, resp_evict_41, resp_wb_41}); end
    n_checks++; if ({hits_41, misses_41, evictions_41, writebacks_41} !== '0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d/%0d/%0d exp 0", hits_41, misses_41, evictions_41, writebacks_41); end
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    issue(31'h0000, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t1_rd0: got %b seen %b exp %b", resp_got, resp_seen, e); end
    n_checks++; if (resp_lat !== 1) begin n_fail++; $display("FAIL t1_latency: got %0d exp 1", resp_lat); end
    n_checks++; if (misses_41 !== 31'd1) begin n_fail++; $display("FAIL t1_misses: got %0d exp 1", misses_41); end
    issue(31'h0004, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t1_rd4: got %b seen %b exp %b", resp_got, resp_seen, e); end
    n_checks++; if (hits_41 !== 31'd1) begin n_fail++; $display("FAIL t1_hits: got %0d exp 1", hits_41); end
  endtask

  task automatic test_fill_evict();
    logic [30:0] addrs [6] = '{31'h0, 31'h800, 31'h1000, 31'h1800, 31'h2000, 31'h0};
    logic [4:0]  e;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0));
    exp_q.push_back(mk(0, 1, 1, 0));
    for (int i = 0; i < 6; i++) begin
      issue(addrs[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t2_rd%0d: got %b seen %b exp %b", i, resp_got, resp_seen, e); end
      if (i == 4) begin
        n_checks++; if (evictions_41 !== 31'd1) begin n_fail++; $display("FAIL t2_evictions: got %0d exp 1", evictions_41); end
      end
    end
    n_checks++; if (misses_41 !== 31'd6 || evictions_41 !== 31'd2) begin n_fail++; $display("FAIL t2_stats: misses %0d evictions %0d exp 6 2", misses_41, evictions_41); end
  endtask

  task automatic test_lru_touch();
    logic [30:0] addrs [6] = '{31'h0, 31'h800, 31'h1000, 31'h1800, 31'h0, 31'h2000};
    logic [4:0]  e;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0));
    for (int i = 0; i < 6; i++) begin
      issue(addrs[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t3_rd%0d: got %b seen %b exp %b", i, resp_got, resp_seen, e); end
    end
    n_checks++; if (hits_41 !== 31'd1) begin n_fail++; $display("FAIL t3_hits: got %0d exp 1", hits_41); end
  endtask

  task automatic test_flush();
    int ready_low, done_cnt;
    bit saw_resp;
    logic [4:0] e;
    do_flush(1'b1, ready_low, done_cnt, saw_resp);
    n_checks++; if (ready_low !== 64) begin n_fail++; $display("FAIL t4_ready_low: got %0d exp 64", ready_low); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t4_done_pulses: got %0d exp 1", done_cnt); end
    n_checks++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL t4_req_taken: got %b exp 0", saw_resp); end
    n_checks++; if (hits_41 !== 31'd1 || misses_41 !== 31'd5 || evictions_41 !== 31'd1) begin n_fail++; $display("FAIL t4_stats_kept: got %0d/%0d/%0d exp 1/5/1", hits_41, misses_41, evictions_41); end
    exp_q.push_back(mk(0, 0, 0, 0));
    issue(31'h0000, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t4_rd0: got %b seen %b exp %b", resp_got, resp_seen, e); end
    n_checks++; if (misses_41 !== 31'd6) begin n_fail++; $display("FAIL t4_misses: got %0d exp 6", misses_41); end
  endtask

  task automatic test_reset_mid_lookup();
    bit saw;
    logic [4:0] e;
    apply_reset();
    exp_q.push_back(mk(0, 0, 0, 0));
    issue(31'h0000, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t5_pre: got %b seen %b exp %b", resp_got, resp_seen, e); end
    @(negedge clk_41);
    req_valid_41 = 1'b1;
    req_addr_41 = 31'h40;
    @(posedge clk_41);
    #1 req_valid_41 = 1'b0;
    rst_n_41 = 1'b0;
    @(negedge clk_41);
    n_checks++; if (resp_valid_41 !== 1'b0 || req_ready_41 !== 1'b1) begin n_fail++; $display("FAIL t5_in_reset: resp_valid %b ready %b exp 0 1", resp_valid_41, req_ready_41); end
    n_checks++; if ({hits_41, misses_41, evictions_41, writebacks_41} !== '0) begin n_fail++; $display("FAIL t5_counters: got %0d/%0d/%0d/%0d exp 0", hits_41, misses_41, evictions_41, writebacks_41); end
    rst_n_41 = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk_41);
      if (resp_valid_41) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t5_orphan_resp: got %b exp 0", saw); end
    exp_q.push_back(mk(0, 0, 0, 0));
    issue(31'h0000, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t5_post: got %b seen %b exp %b", resp_got, resp_seen, e); end
  endtask

  task automatic test_writeback();
    logic [30:0] addrs [5] = '{31'h0, 31'h800, 31'h1000, 31'h1800, 31'h2000};
    logic [4:0]  e;
    int ready_low, done_cnt;
    bit saw_resp;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i, 0, 0));
    exp_q.push_back(mk(0, 0, 1, WB));
    for (int i = 0; i < 5; i++) begin
      issue(addrs[i], i == 0);
      e = exp_q.pop_front();
      n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t6_acc%0d: got %b seen %b exp %b", i, resp_got, resp_seen, e); end
    end
    n_checks++; if (writebacks_41 !== 31'(WB)) begin n_fail++; $display("FAIL t6_wb_evict: got %0d exp %0d", writebacks_41, WB); end
    do_flush(1'b0, ready_low, done_cnt, saw_resp);
    n_checks++; if (writebacks_41 !== 31'(WB)) begin n_fail++; $display("FAIL t6_wb_clean_flush: got %0d exp %0d", writebacks_41, WB); end
    exp_q.push_back(mk(0, 0, 0, 0));
    issue(31'h0020, 1'b1);
    e = exp_q.pop_front();
    n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL t6_wr_set1: got %b seen %b exp %b", resp_got, resp_seen, e); end
    do_flush(1'b0, ready_low, done_cnt, saw_resp);
    n_checks++; if (writebacks_41 !== 31'(2 * WB)) begin n_fail++; $display("FAIL t6_wb_dirty_flush: got %0d exp %0d", writebacks_41, 2 * WB); end
  endtask

  task automatic test_back_to_back();
    logic [30:0] addrs [4];
    logic [4:0]  e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      addrs[i] = {20'($urandom_range(0, 20'hFFFFF)), 6'(i * 16 + $urandom_range(0, 15)), 5'd0};
      exp_q.push_back(mk(0, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      issue(addrs[i % 4] | 31'($urandom_range(0, 31)), 1'b0);
      e = exp_q.pop_front();
      n_checks++; if (!resp_seen || resp_got !== e) begin n_fail++; $display("FAIL b2b_%0d: got %b seen %b exp %b", i, resp_got, resp_seen, e); end
    end
    n_checks++; if (hits_41 !== 31'd4 || misses_41 !== 31'd4) begin n_fail++; $display("FAIL b2b_stats: hits %0d misses %0d exp 4 4", hits_41, misses_41); end
  endtask

  initial begin
    test_reset_hit();
    test_fill_evict();
    test_lru_touch();
    test_flush();
    test_reset_mid_lookup();
    test_writeback();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
